// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped BTB with bimodal or gshare saturating-counter direction prediction
module bpred_btb #(
  parameter int ENTRIES = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int HIST_BITS = 0,
  localparam int GHW = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [31:0]    lu_pc,
  output logic           pred_hit,
  output logic           pred_taken,
  output logic [31:0]    pred_target,
  output logic [GHW-1:0] lu_ghist,
  input  logic           upd_valid,
  input  logic [31:0]    upd_pc,
  input  logic           upd_taken,
  input  logic [31:0]    upd_target,
  input  logic           upd_pred_taken,
  input  logic [GHW-1:0] upd_ghist,
  output logic [31:0]    perf_branches,
  output logic [31:0]    perf_mispred
);
  localparam int IW = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - 1'b1;
  logic [ENTRIES-1:0]               valid;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tags;
  logic [ENTRIES-1:0][31:0]         targets;
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctrs;
  logic [GHW-1:0]      ghist;
  logic [GHW-1:0]      upd_hist;
  logic [IW-1:0]       lu_idx;
  logic [IW-1:0]       upd_idx;
  logic [TAG_BITS-1:0] lu_tag;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic                unused;
  // bimodal mode keeps ghist at zero, so the XOR below degenerates to the base index
  assign upd_hist = (HIST_BITS > 0) ? upd_ghist : '0;
  assign lu_idx = lu_pc[IW+1:2] ^ IW'(ghist);
  assign upd_idx = upd_pc[IW+1:2] ^ IW'(upd_hist);
  assign lu_tag = lu_pc[IW+TAG_BITS+1:IW+2];
  assign upd_tag = upd_pc[IW+TAG_BITS+1:IW+2];
  assign lu_ghist = ghist;
  assign pred_hit = valid[lu_idx] && (tags[lu_idx] == lu_tag);
  assign pred_taken = pred_hit && ctrs[lu_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? targets[lu_idx] : lu_pc + 32'd4;
  assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);
  assign ctr_cur = ctrs[upd_idx];
  assign ctr_next = upd_taken ? ((ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1)
                              : ((ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1);
  assign unused = ^{lu_pc, upd_pc, upd_ghist};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      tags <= '0;
      targets <= '0;
      ctrs <= {ENTRIES{CTR_WNT}};
      ghist <= '0;
      perf_branches <= '0;
      perf_mispred <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctrs[upd_idx] <= ctr_next;
        if (upd_taken) targets[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid[upd_idx] <= 1'b1;
        tags[upd_idx] <= upd_tag;
        targets[upd_idx] <= upd_target;
        ctrs[upd_idx] <= CTR_WT;
      end
      ghist <= (HIST_BITS > 0) ? GHW'({ghist, upd_taken}) : '0;
      perf_branches <= perf_branches + {31'd0, perf_branches != '1};
      perf_mispred <= perf_mispred + {31'd0, (upd_taken != upd_pred_taken) && (perf_mispred != '1)};
    end
  end
endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: bimodal and gshare BTB instances checked against an array-based table model
module tb_bpred_btb;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [31:0] lu_pc = 32'h0, upd_pc = 32'h0, upd_target = 32'h0;
  logic upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [0:0] gh_b_in = 1'b0;
  logic [3:0] gh_g_in = 4'h0;
  logic b_hit, b_taken, g_hit, g_taken;
  logic [31:0] b_target, g_target, b_br, b_mp, g_br, g_mp;
  logic [0:0] b_ghist;
  logic [3:0] g_ghist;
  int total = 0, bad = 0;
  bit m_v[2][256];
  int m_tag[2][256];
  int m_ctr[2][256];
  logic [31:0] m_tgt[2][256];
  int m_h;
  longint m_br, m_mp;

  always #5 clk = ~clk;

  bpred_btb u_bim (
    .clk(clk), .reset_n(reset_n), .lu_pc(lu_pc), .pred_hit(b_hit), .pred_taken(b_taken),
    .pred_target(b_target), .lu_ghist(b_ghist), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_ghist(gh_b_in), .perf_branches(b_br), .perf_mispred(b_mp)
  );

  bpred_btb #(.ENTRIES(256), .HIST_BITS(4)) u_gs (
    .clk(clk), .reset_n(reset_n), .lu_pc(lu_pc), .pred_hit(g_hit), .pred_taken(g_taken),
    .pred_target(g_target), .lu_ghist(g_ghist), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_ghist(gh_g_in), .perf_branches(g_br), .perf_mispred(g_mp)
  );

  // config 0 = 64-entry bimodal, config 1 = 256-entry gshare with 4 history bits
  function automatic int ents(input int c);
    return c != 0 ? 256 : 64;
  endfunction

  function automatic int m_idx(input int c, input logic [31:0] pc, input int gh);
    return (int'(pc >> 2) & (ents(c) - 1)) ^ (c != 0 ? gh : 0);
  endfunction

  function automatic int m_tagof(input int c, input logic [31:0] pc);
    return int'(pc >> ($clog2(ents(c)) + 2)) & 255;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 256; i++) begin
        m_v[c][i] = 1'b0; m_tag[c][i] = 0; m_ctr[c][i] = 1; m_tgt[c][i] = 32'h0;
      end
    m_h = 0; m_br = 0; m_mp = 0;
  endtask

  task automatic m_predict(input int c, input logic [31:0] pc, output bit hit, output bit tk,
                           output logic [31:0] tgt);
    int i;
    i = m_idx(c, pc, m_h);
    hit = m_v[c][i] && m_tag[c][i] == m_tagof(c, pc);
    tk = hit && m_ctr[c][i] >= 2;
    tgt = tk ? m_tgt[c][i] : pc + 32'd4;
  endtask

  task automatic m_update();
    for (int c = 0; c < 2; c++) begin
      int i, t;
      i = m_idx(c, upd_pc, int'(gh_g_in));
      t = m_tagof(c, upd_pc);
      if (m_v[c][i] && m_tag[c][i] == t) begin
        m_ctr[c][i] = upd_taken ? (m_ctr[c][i] < 3 ? m_ctr[c][i] + 1 : 3) : (m_ctr[c][i] > 0 ? m_ctr[c][i] - 1 : 0);
        if (upd_taken) m_tgt[c][i] = upd_target;
      end else if (upd_taken) begin
        m_v[c][i] = 1'b1; m_tag[c][i] = t; m_tgt[c][i] = upd_target; m_ctr[c][i] = 2;
      end
    end
    m_h = ((m_h << 1) | int'(upd_taken)) & 15;
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (upd_taken != upd_pred_taken && m_mp < 64'hFFFF_FFFF) m_mp++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (upd_valid && reset_n) m_update();
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ptk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
    gh_g_in = 4'(m_h);
    gh_b_in = 1'($urandom);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ptk);
    set_upd(pc, tk, tgt, ptk);
    tick();
  endtask

  task automatic do_reset();
    upd_valid = 1'b0;
    #1 reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    m_reset();
    lu_pc = 32'hFFFF_FFFC;
    #1;
    total++; if (b_target !== 32'h0) begin bad++; $display("FAIL rst_wrap got=%h want=%h", b_target, 32'h0); end
    total++; if ({b_hit, b_taken, g_hit, g_taken} !== 4'b0) begin bad++; $display("FAIL rst_hit got=%b want=0000", {b_hit, b_taken, g_hit, g_taken}); end
    total++; if ({g_ghist, b_ghist} !== 5'b0) begin bad++; $display("FAIL rst_ghist got=%b want=00000", {g_ghist, b_ghist}); end
    total++; if ({b_br, b_mp, g_br, g_mp} !== 128'b0) begin bad++; $display("FAIL rst_perf got=%h want=0", {b_br, b_mp, g_br, g_mp}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_cold();
    lu_pc = 32'h100;
    #1;
    total++; if ({b_hit, b_taken} !== 2'b00) begin bad++; $display("FAIL cold_hit got=%b want=00", {b_hit, b_taken}); end
    total++; if (b_target !== 32'h104) begin bad++; $display("FAIL cold_target got=%h want=%h", b_target, 32'h104); end
  endtask

  task automatic test_alloc_train();
    upd(32'h100, 1'b1, 32'h40, 1'b0);
    lu_pc = 32'h100; #1;
    total++; if ({b_hit, b_taken, b_target} !== {2'b11, 32'h40}) begin bad++; $display("FAIL alloc got=%b%b %h want=11 00000040", b_hit, b_taken, b_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b1); #1;
    total++; if ({b_hit, b_taken, b_target} !== {2'b10, 32'h104}) begin bad++; $display("FAIL train_nt1 got=%b%b %h want=10 00000104", b_hit, b_taken, b_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b0); #1;
    total++; if ({b_hit, b_taken, b_target} !== {2'b10, 32'h104}) begin bad++; $display("FAIL train_nt2 got=%b%b %h want=10 00000104", b_hit, b_taken, b_target); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h40, 1'b0);
    #1;
    total++; if ({b_taken, b_target} !== {1'b1, 32'h40}) begin bad++; $display("FAIL sat_taken got=%b %h want=1 00000040", b_taken, b_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b1); #1;
    total++; if (b_taken !== 1'b1) begin bad++; $display("FAIL sat_dec1 got=%b want=1", b_taken); end
    upd(32'h100, 1'b0, 32'h0, 1'b1); #1;
    total++; if (b_taken !== 1'b0) begin bad++; $display("FAIL sat_dec2 got=%b want=0", b_taken); end
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h100, 1'b1, 32'h40, 1'b0);
    set_upd(32'h4100, 1'b1, 32'h80, 1'b0);
    lu_pc = 32'h100; #1;
    total++; if ({b_hit, b_target} !== {1'b1, 32'h40}) begin bad++; $display("FAIL same_cycle_old got=%b %h want=1 00000040", b_hit, b_target); end
    lu_pc = 32'h4100; #1;
    total++; if ({b_hit, b_target} !== {1'b0, 32'h4104}) begin bad++; $display("FAIL same_cycle_new got=%b %h want=0 00004104", b_hit, b_target); end
    tick();
    lu_pc = 32'h100; #1;
    total++; if ({b_hit, b_target} !== {1'b0, 32'h104}) begin bad++; $display("FAIL alias_evict got=%b %h want=0 00000104", b_hit, b_target); end
    lu_pc = 32'h4100; #1;
    total++; if ({b_hit, b_taken, b_target} !== {2'b11, 32'h80}) begin bad++; $display("FAIL alias_new got=%b%b %h want=11 00000080", b_hit, b_taken, b_target); end
  endtask

  task automatic test_gshare();
    do_reset();
    upd(32'h11C, 1'b1, 32'h5000, 1'b1);
    upd(32'h200, 1'b1, 32'h6000, 1'b1);
    upd(32'h300, 1'b1, 32'h7000, 1'b1);
    lu_pc = 32'h100; #1;
    total++; if (g_ghist !== 4'b0111) begin bad++; $display("FAIL gs_hist got=%b want=0111", g_ghist); end
    total++; if (b_ghist !== 1'b0) begin bad++; $display("FAIL bim_hist got=%b want=0", b_ghist); end
    total++; if ({g_hit, g_taken, g_target} !== {2'b11, 32'h5000}) begin bad++; $display("FAIL gs_idx47 got=%b%b %h want=11 00005000", g_hit, g_taken, g_target); end
    lu_pc = 32'h11C; #1;
    total++; if ({g_hit, g_target} !== {1'b0, 32'h120}) begin bad++; $display("FAIL gs_miss got=%b %h want=0 00000120", g_hit, g_target); end
  endtask

  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 10; i++) upd(32'h800 + 32'(4 * i), 1'(i % 2), 32'h900, (i < 3) ? 1'(~(i % 2)) : 1'(i % 2));
    total++; if ({b_br, b_mp} !== {32'd10, 32'd3}) begin bad++; $display("FAIL perf_bim got=%0d/%0d want=10/3", b_br, b_mp); end
    total++; if ({g_br, g_mp} !== {32'd10, 32'd3}) begin bad++; $display("FAIL perf_gs got=%0d/%0d want=10/3", g_br, g_mp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    upd(32'h100, 1'b1, 32'h40, 1'b0);
    set_upd(32'h100, 1'b1, 32'h90, 1'b0);
    lu_pc = 32'h100; #1;
    total++; if (b_hit !== 1'b1) begin bad++; $display("FAIL pre_reset_hit got=%b want=1", b_hit); end
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    total++; if ({b_hit, b_taken, b_target} !== {2'b00, 32'h104}) begin bad++; $display("FAIL async_rst got=%b%b %h want=00 00000104", b_hit, b_taken, b_target); end
    total++; if ({g_ghist, b_br, g_mp} !== 68'b0) begin bad++; $display("FAIL async_rst_state got=%h want=0", {g_ghist, b_br, g_mp}); end
    tick();
    upd_valid = 1'b1; #1;
    total++; if ({b_hit, b_br} !== 33'b0) begin bad++; $display("FAIL rst_hold got=%b %0d want=0 0", b_hit, b_br); end
    upd_valid = 1'b0;
    reset_n = 1'b1;
    upd(32'h100, 1'b1, 32'h44, 1'b0); #1;
    total++; if ({b_hit, b_target, b_br} !== {1'b1, 32'h44, 32'd1}) begin bad++; $display("FAIL first_upd got=%b %h %0d want=1 00000044 1", b_hit, b_target, b_br); end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] pool [6] = '{32'h100, 32'h4100, 32'h11C, 32'h200, 32'h104, 32'h40100};
    return ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 5)];
  endfunction

  task automatic test_random();
    bit hit, tk;
    logic [31:0] tgt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_upd(pick(), $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC, 1'($urandom));
      upd_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) gh_g_in = 4'($urandom);
      lu_pc = pick();
      #1;
      m_predict(0, lu_pc, hit, tk, tgt);
      total++; if ({b_hit, b_taken, b_target} !== {hit, tk, tgt}) begin bad++; $display("FAIL rnd_bim n=%0d pc=%h got=%b%b %h want=%b%b %h", n, lu_pc, b_hit, b_taken, b_target, hit, tk, tgt); end
      m_predict(1, lu_pc, hit, tk, tgt);
      total++; if ({g_hit, g_taken, g_target} !== {hit, tk, tgt}) begin bad++; $display("FAIL rnd_gs n=%0d pc=%h got=%b%b %h want=%b%b %h", n, lu_pc, g_hit, g_taken, g_target, hit, tk, tgt); end
      total++; if ({g_ghist, b_ghist} !== {4'(m_h), 1'b0}) begin bad++; $display("FAIL rnd_hist n=%0d got=%b want=%b", n, {g_ghist, b_ghist}, {4'(m_h), 1'b0}); end
      total++; if ({b_br, b_mp, g_br, g_mp} !== {32'(m_br), 32'(m_mp), 32'(m_br), 32'(m_mp)}) begin bad++; $display("FAIL rnd_perf n=%0d got=%0d/%0d want=%0d/%0d", n, b_br, b_mp, m_br, m_mp); end
      tick();
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_cold();
    test_alloc_train();
    test_saturation();
    test_alias();
    test_gshare();
    test_perf();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bpred_btb.md
BPRED_BTB -- requirements
Module: bpred_btb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters (name, default, meaning):
- ENTRIES, 64: table depth, power of 2, minimum 4.
- CTR_BITS, 2: saturating counter width, 1..4.
- TAG_BITS, 8: stored tag width.
- HIST_BITS, 0: global history length; 0 selects bimodal, otherwise gshare; must not exceed log2(ENTRIES).
REQ-003 Ports, clock and reset (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous active-low reset.
REQ-004 Ports, lookup (fetch side):
- lu_pc, in, 32: fetch PC.
- pred_hit, out, 1: BTB tag hit.
- pred_taken, out, 1: predicted taken.
- pred_target, out, 32: predicted next PC.
- lu_ghist, out, GHW: history value used for this lookup.
REQ-005 Ports, update (execute side):
- upd_valid, in, 1: a resolved branch is presented this cycle.
- upd_pc, in, 32: PC of the resolved branch.
- upd_taken, in, 1: actual branch outcome.
- upd_target, in, 32: actual taken target.
- upd_pred_taken, in, 1: prediction that was made for this branch.
- upd_ghist, in, GHW: lu_ghist value carried down the pipeline with the branch.
- perf_branches, out, 32: count of resolved branches.
- perf_mispred, out, 32: count of mispredictions.
REQ-006 GHW SHALL be HIST_BITS when HIST_BITS > 0, and 1 otherwise. When HIST_BITS = 0, lu_ghist SHALL be driven to 0 and upd_ghist SHALL be ignored.

Function
REQ-007 Each entry SHALL hold: valid (1 bit), tag (TAG_BITS), target (32 bits), counter (CTR_BITS).
REQ-008 Address fields: IW = log2(ENTRIES); base index = pc[IW+1:2]; tag = pc[IW+TAG_BITS+1:IW+2].
REQ-009 The lookup index SHALL be base index XOR {zero-pad, ghist}. The ghist value is the current history for lookup and upd_ghist for update.
REQ-010 Lookup SHALL be combinational, with zero-cycle latency:
- pred_hit = valid AND tag match.
- pred_taken = pred_hit AND counter MSB.
- pred_target = stored target if pred_taken, otherwise lu_pc + 4, with 32-bit wrap (0xFFFFFFFC gives 0x00000000).
REQ-011 On upd_valid with a tag hit:
- The counter SHALL increment when upd_taken = 1 and decrement when upd_taken = 0.
- The counter SHALL saturate at 2^CTR_BITS-1 and at 0.
- The target SHALL be rewritten with upd_target only when upd_taken = 1.
REQ-012 On upd_valid with a miss and upd_taken = 1, the indexed entry SHALL be allocated or overwritten: valid = 1, new tag, target = upd_target, counter = 2^(CTR_BITS-1) (weakly taken).
REQ-013 On upd_valid with a miss and upd_taken = 0, the table SHALL not change.
REQ-014 On upd_valid with HIST_BITS > 0, the global history SHALL shift left by one, inserting upd_taken at bit 0.
REQ-015 On upd_valid, perf_branches SHALL increment. perf_mispred SHALL increment when upd_taken != upd_pred_taken. Both counters SHALL saturate at 0xFFFFFFFF.
REQ-016 Lookup and update to the same index in the same cycle: the lookup SHALL return the pre-update contents, with no bypass. The new contents SHALL be visible on the next cycle.
REQ-017 When upd_valid = 0, no state SHALL change.
REQ-018 All table state SHALL be flop-based so that it clears under asynchronous reset; no RAM inference.

Reset
REQ-019 While reset_n = 0, and immediately on its assertion (including mid-update):
- all valid bits = 0;
- counters = 2^(CTR_BITS-1)-1 (weakly not-taken);
- targets and tags = 0;
- history = 0;
- perf_branches and perf_mispred = 0.
REQ-020 During reset, outputs SHALL read pred_hit = 0, pred_taken = 0, pred_target = lu_pc + 4, lu_ghist = 0.
REQ-021 The first update SHALL take effect on the first rising clk edge after reset_n deasserts.

Verification
REQ-022 Cold lookup: after reset, lu_pc = 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0x104.
REQ-023 Allocate, then train (defaults):
- Update pc 0x100, taken, target 0x40 -> next cycle pred_hit = 1, pred_taken = 1, pred_target = 0x40.
- Two not-taken updates -> counter 0, pred_taken = 0, pred_target = 0x104, pred_hit = 1.
REQ-024 Saturation: five taken updates on an allocated entry -> counter 3; one not-taken -> counter 2, still predicted taken.
REQ-025 Aliasing and same-cycle behaviour:
- Update pc 0x100 then pc 0x4100 (same index, different tag), both taken -> lookup 0x100 misses; lookup 0x4100 hits.
- A same-cycle lookup during the second update returns the old entry.
REQ-026 Gshare (HIST_BITS = 4): three taken updates -> lu_ghist = 0b0111. Lookup 0x100 indexes entry 0x40 ^ 0x7 = 0x47.
REQ-027 Counters and reset:
- Ten updates, three with upd_taken != upd_pred_taken -> perf_branches = 10, perf_mispred = 3.
- Asserting reset_n = 0 mid-cycle -> all outputs return to reset values without waiting for a clock edge.
